plic_claim_arb: RTL and testbench
=================================

# plic_claim_arb

Multi-context claim/complete arbiter between N hart contexts and the single claim/complete port of the PLIC core. It serialises claim and complete requests with round-robin fairness, pulses the core's claim/complete strobes, captures the returned interrupt ID and routes it back to the requesting context. It also tracks one outstanding claimed ID per context and flags completes that do not match that ID.

## Interface
- NUM_CTX, 4, number of requesting contexts (2..8)
- IRQ_WIDTH, 5, interrupt ID width (IDs 0..31; ID 0 means no interrupt)
- clk_i  in  1  clock
- rst_n_i  in  1  reset; one clock, reset is asynchronous and active-low
- clm_valid_i  in  NUM_CTX  per-context claim request; held until clm_ready_o
- clm_ready_o  out  NUM_CTX  claim accepted (one-hot, one cycle)
- rsp_valid_o  out  NUM_CTX  claim response strobe (one-hot, one cycle, no backpressure)
- rsp_id_o  out  IRQ_WIDTH  claimed ID; valid only while any rsp_valid_o bit is high, else 0
- cmp_valid_i  in  NUM_CTX  per-context complete request; held until cmp_ready_o
- cmp_id_i  in  NUM_CTX*IRQ_WIDTH  complete ID; context k uses bits [k*IRQ_WIDTH +: IRQ_WIDTH]
- cmp_ready_o  out  NUM_CTX  complete accepted (one-hot, one cycle)
- busy_o  out  NUM_CTX  context holds an outstanding non-zero claim
- err_o  out  1  sticky: mismatched or unexpected complete seen
- err_clr_i  in  1  synchronous clear of err_o
- clam_o  out  1  claim strobe to the core
- id_i  in  IRQ_WIDTH  core's current highest-priority ID; combinational, sampled while clam_o is high
- comp_o  out  1  complete strobe to the core
- comp_id_o  out  IRQ_WIDTH  ID being completed; 0 when comp_o is low

## Operation
- FSM states: IDLE, CLAIM, RESP, COMP. Reset state is IDLE.
- Per-context registers: own_id[k] (IRQ_WIDTH bits) and busy[k].
- Eligibility:
  - Claim from k is eligible when clm_valid_i[k] && !busy[k].
  - Complete from k is eligible when cmp_valid_i[k]. It is valid only if busy[k] and cmp_id == own_id[k].
  - A busy context's claim is never eligible. Claim and complete from one context therefore never compete.
- Arbitration in IDLE:
  - Any eligible complete beats every claim.
  - Within each class, the winner is the first eligible index starting at rr_q and counting upward modulo NUM_CTX.
  - On any grant, rr_q becomes winner+1 (wraps from NUM_CTX-1 to 0).
- Accepting a complete:
  - cmp_ready_o[k] = 1 in IDLE, then go to COMP.
  - In COMP, a valid complete gives comp_o = 1, comp_id_o = own_id[k], and clears busy[k] and own_id[k].
  - In COMP, an invalid complete gives comp_o = 0 and sets err_o; busy and own_id are unchanged.
  - COMP always returns to IDLE.
- Accepting a claim:
  - clm_ready_o[k] = 1 in IDLE, then go to CLAIM.
  - In CLAIM, clam_o = 1. id_i is registered into own_id[k]. busy[k] is set iff id_i != 0.
  - CLAIM always goes to RESP.
  - In RESP, rsp_valid_o[k] = 1 and rsp_id_o = own_id[k]. RESP then returns to IDLE.
- err_o:
  - Set in COMP for an invalid complete; clear when err_clr_i = 1.
  - If set and clear occur in the same cycle, set wins.
- No grants are issued in CLAIM, RESP or COMP. Requests simply stay pending.

## Timing
- Reset (asynchronous): every output is 0; rr_q = 0; all busy, own_id and err cleared; FSM in IDLE. An operation in flight is abandoned with no strobe.
- clm_ready_o and cmp_ready_o are combinational from IDLE plus the request inputs. All other outputs are decoded from registered state.
- Claim: accept at cycle T, clam_o at T+1, rsp_valid_o at T+2, IDLE at T+3. Sustained claim throughput is 1 per 3 cycles.
- Complete: accept at cycle T, comp_o at T+1, IDLE at T+2.
- busy_o is updated at the end of CLAIM or COMP, so it is visible in the following cycle.
- A context may re-claim in the cycle after its RESP, provided busy is clear.

## Test plan
- Single claim: core id_i = 7, ctx1 claims. Expect clm_ready_o = 0010, then clam_o, then rsp_valid_o = 0010 with rsp_id_o = 7; busy_o = 0010.
- Round-robin: all 4 contexts claim at once from reset, id_i = 3, 4, 5, 6 in turn. Expect grants in order 0, 1, 2, 3, each 3 cycles apart, and rsp_id_o = 3, 4, 5, 6.
- Complete priority: ctx2 is busy with ID 9; ctx2 completes 9 while ctx0 claims in the same cycle. Expect cmp_ready_o = 0100 first, comp_o = 1 with comp_id_o = 9, busy_o[2] = 0, and ctx0 granted 2 cycles later.
- Mismatch: ctx0 is busy with ID 4 and completes ID 5. Expect cmp_ready_o = 0001, comp_o = 0, err_o = 1, busy_o[0] still 1. Then err_clr_i = 1 gives err_o = 0.
- Zero ID: id_i = 0, ctx3 claims. Expect rsp_id_o = 0 and busy_o[3] = 0. A later complete from ctx3 sets err_o.
- Reset mid-claim: assert rst_n_i = 0 during CLAIM. Expect every output 0 immediately, no rsp_valid_o, busy_o = 0, and the next grant starts from ctx0.

Source files
------------

// File: rtl/plic_claim_arb.sv
// Purpose : round-robin claim/complete arbiter between NUM_CTX hart contexts and one PLIC core port.
// Latency : claim accept T -> clam_o T+1 -> rsp_valid_o T+2 -> idle T+3; complete accept T -> comp_o T+1 -> idle T+2.
// Backpress: requests are held by the contexts until their ready pulse; responses have no backpressure.
//
// Ports:
//   clk_i, rst_n_i               clock, asynchronous active-low reset
//   clm_valid_i / clm_ready_o    per-context claim request / one-hot accept
//   rsp_valid_o / rsp_id_o       one-hot claim response strobe and claimed ID
//   cmp_valid_i / cmp_id_i       per-context complete request and ID (ctx k at [k*IRQ_WIDTH +: IRQ_WIDTH])
//   cmp_ready_o                  one-hot complete accept
//   busy_o                       context holds an outstanding non-zero claim
//   err_o / err_clr_i            sticky bad-complete flag and its synchronous clear
//   clam_o / id_i                claim strobe to the core and the core's current top ID
//   comp_o / comp_id_o           complete strobe to the core and the ID being completed
module plic_claim_arb #(
    parameter int NUM_CTX   = 4,
    parameter int IRQ_WIDTH = 5
) (
    input  logic                           clk_i,
    input  logic                           rst_n_i,
    input  logic [NUM_CTX-1:0]             clm_valid_i,
    output logic [NUM_CTX-1:0]             clm_ready_o,
    output logic [NUM_CTX-1:0]             rsp_valid_o,
    output logic [IRQ_WIDTH-1:0]           rsp_id_o,
    input  logic [NUM_CTX-1:0]             cmp_valid_i,
    input  logic [NUM_CTX*IRQ_WIDTH-1:0]   cmp_id_i,
    output logic [NUM_CTX-1:0]             cmp_ready_o,
    output logic [NUM_CTX-1:0]             busy_o,
    output logic                           err_o,
    input  logic                           err_clr_i,
    output logic                           clam_o,
    input  logic [IRQ_WIDTH-1:0]           id_i,
    output logic                           comp_o,
    output logic [IRQ_WIDTH-1:0]           comp_id_o
);

    localparam int IDXW = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLAIM = 2'd1,
        RESP  = 2'd2,
        COMP  = 2'd3
    } state_t;

    state_t                              state_q, state_d;
    logic [IDXW-1:0]                     sel_q, sel_d;      // context owning the operation in flight
    logic [IDXW-1:0]                     rr_q, rr_d;        // round-robin search start
    logic [NUM_CTX-1:0][IRQ_WIDTH-1:0]   own_id_q, own_id_d;
    logic [NUM_CTX-1:0]                  busy_q, busy_d;
    logic                                err_q, err_d;
    logic                                cmp_ok_q, cmp_ok_d; // complete matched the owned ID at accept

    logic [NUM_CTX-1:0][IRQ_WIDTH-1:0]   cmp_id_arr;
    logic                                cmp_win_vld, clm_win_vld;
    logic [IDXW-1:0]                     cmp_win, clm_win;
    logic [IDXW-1:0]                     idx;

    assign cmp_id_arr = cmp_id_i;

    function automatic logic [IDXW-1:0] next_idx(input logic [IDXW-1:0] w);
        if (w == IDXW'(NUM_CTX - 1)) begin
            return '0;
        end
        return w + IDXW'(1);
    endfunction

    // First eligible request of each class, searching upward from rr_q.
    always_comb begin
        cmp_win_vld = 1'b0;
        cmp_win     = '0;
        clm_win_vld = 1'b0;
        clm_win     = '0;
        idx         = '0;
        for (int i = 0; i < NUM_CTX; i++) begin
            idx = IDXW'((int'(rr_q) + i) % NUM_CTX);
            if (!cmp_win_vld && cmp_valid_i[idx]) begin
                cmp_win_vld = 1'b1;
                cmp_win     = idx;
            end
            // A busy context may not claim again until its complete retires.
            if (!clm_win_vld && clm_valid_i[idx] && !busy_q[idx]) begin
                clm_win_vld = 1'b1;
                clm_win     = idx;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        rr_d        = rr_q;
        own_id_d    = own_id_q;
        busy_d      = busy_q;
        cmp_ok_d    = cmp_ok_q;
        err_d       = err_clr_i ? 1'b0 : err_q;
        clm_ready_o = '0;
        cmp_ready_o = '0;

        unique case (state_q)
            IDLE: begin
                // Ready is combinational, so it is held low while reset is asserted.
                if (rst_n_i) begin
                    if (cmp_win_vld) begin
                        cmp_ready_o[cmp_win] = 1'b1;
                        sel_d    = cmp_win;
                        rr_d     = next_idx(cmp_win);
                        // Capture validity now: the context may drop its ID once accepted.
                        cmp_ok_d = busy_q[cmp_win] && (cmp_id_arr[cmp_win] == own_id_q[cmp_win]);
                        state_d  = COMP;
                    end else if (clm_win_vld) begin
                        clm_ready_o[clm_win] = 1'b1;
                        sel_d   = clm_win;
                        rr_d    = next_idx(clm_win);
                        state_d = CLAIM;
                    end
                end
            end
            CLAIM: begin
                own_id_d[sel_q] = id_i;
                busy_d[sel_q]   = |id_i;
                state_d         = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            COMP: begin
                if (cmp_ok_q) begin
                    busy_d[sel_q]   = 1'b0;
                    own_id_d[sel_q] = '0;
                end else begin
                    err_d = 1'b1;   // set wins over a simultaneous clear
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            rr_q     <= '0;
            own_id_q <= '0;
            busy_q   <= '0;
            err_q    <= 1'b0;
            cmp_ok_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            rr_q     <= rr_d;
            own_id_q <= own_id_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            cmp_ok_q <= cmp_ok_d;
        end
    end

    // Strobes and data toward the core and the contexts, decoded from registered state.
    assign clam_o      = (state_q == CLAIM);
    assign comp_o      = (state_q == COMP) && cmp_ok_q;
    assign comp_id_o   = comp_o ? own_id_q[sel_q] : '0;
    assign rsp_valid_o = (state_q == RESP) ? (NUM_CTX'(1) << sel_q) : '0;
    assign rsp_id_o    = (state_q == RESP) ? own_id_q[sel_q] : '0;
    assign busy_o      = busy_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_plic_claim_arb.sv
// Randomized and directed bench for plic_claim_arb against a transaction-level reference model.
module tb_plic_claim_arb;

    localparam int N = 4;
    localparam int W = 5;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [N-1:0]       clm_valid = '0;
    logic [N-1:0]       clm_ready;
    logic [N-1:0]       rsp_valid;
    logic [W-1:0]       rsp_id;
    logic [N-1:0]       cmp_valid = '0;
    logic [N-1:0][W-1:0] cmp_id = '0;
    logic [N-1:0]       cmp_ready;
    logic [N-1:0]       busy;
    logic               err;
    logic               err_clr = 1'b0;
    logic               clam;
    logic [W-1:0]       id = '0;
    logic               comp;
    logic [W-1:0]       comp_id;

    plic_claim_arb #(.NUM_CTX(N), .IRQ_WIDTH(W)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .clm_valid_i (clm_valid),
        .clm_ready_o (clm_ready),
        .rsp_valid_o (rsp_valid),
        .rsp_id_o    (rsp_id),
        .cmp_valid_i (cmp_valid),
        .cmp_id_i    (cmp_id),
        .cmp_ready_o (cmp_ready),
        .busy_o      (busy),
        .err_o       (err),
        .err_clr_i   (err_clr),
        .clam_o      (clam),
        .id_i        (id),
        .comp_o      (comp),
        .comp_id_o   (comp_id)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Stimulus shadows, applied to the DUT at the next falling edge.
    logic               d_rst = 1'b0;
    logic [N-1:0]       d_clm = '0;
    logic [N-1:0]       d_cmp = '0;
    logic [N-1:0][W-1:0] d_cmp_id = '0;
    logic [W-1:0]       d_id = '0;
    logic               d_clr = 1'b0;

    // Sampled DUT outputs of the latest cycle.
    logic [N-1:0] s_clm_rdy, s_cmp_rdy, s_rsp_vld, s_busy;
    logic [W-1:0] s_rsp_id, s_comp_id;
    logic         s_clam, s_comp, s_err;

    // Reference model: which transaction is in flight and how far along it is.
    localparam int OP_NONE = 0, OP_CLAIM = 1, OP_COMP = 2;
    int           m_op = OP_NONE;
    int           m_phase = 0;
    int           m_who = 0;
    bit           m_ok = 1'b0;
    int           m_rr = 0;
    bit [N-1:0]   m_busy = '0;
    int           m_own [N];
    bit           m_err = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        int e_clm, e_cmp, e_rsp, e_rsp_id, e_clam, e_comp, e_comp_id, e_busy, e_err;
        int w;
        int k;
        @(negedge clk);
        rst_n     = d_rst;
        clm_valid = d_clm;
        cmp_valid = d_cmp;
        cmp_id    = d_cmp_id;
        id        = d_id;
        err_clr   = d_clr;
        #1;
        s_clm_rdy = clm_ready; s_cmp_rdy = cmp_ready; s_rsp_vld = rsp_valid; s_busy = busy;
        s_rsp_id = rsp_id; s_comp_id = comp_id; s_clam = clam; s_comp = comp; s_err = err;

        e_clm = 0; e_cmp = 0; e_rsp = 0; e_rsp_id = 0; e_clam = 0; e_comp = 0; e_comp_id = 0;
        if (!d_rst) begin
            m_op = OP_NONE; m_phase = 0; m_rr = 0; m_busy = '0; m_err = 1'b0;
            for (int j = 0; j < N; j++) m_own[j] = 0;
            e_busy = 0; e_err = 0;
        end else begin
            e_busy = int'(m_busy);
            e_err  = int'(m_err);
            if (d_clr) m_err = 1'b0;
            if (m_op == OP_NONE) begin
                w = -1;
                for (int i = 0; i < N; i++) begin
                    k = (m_rr + i) % N;
                    if (w < 0 && d_cmp[k]) w = k;
                end
                if (w >= 0) begin
                    e_cmp = 1 << w;
                    m_ok  = m_busy[w] && (int'(d_cmp_id[w]) == m_own[w]);
                    m_op  = OP_COMP; m_who = w; m_rr = (w + 1) % N;
                end else begin
                    for (int i = 0; i < N; i++) begin
                        k = (m_rr + i) % N;
                        if (w < 0 && d_clm[k] && !m_busy[k]) w = k;
                    end
                    if (w >= 0) begin
                        e_clm = 1 << w;
                        m_op = OP_CLAIM; m_phase = 1; m_who = w; m_rr = (w + 1) % N;
                    end
                end
            end else if (m_op == OP_CLAIM && m_phase == 1) begin
                e_clam = 1;
                m_own[m_who]  = int'(d_id);
                m_busy[m_who] = (d_id != 0);
                m_phase = 2;
            end else if (m_op == OP_CLAIM) begin
                e_rsp = 1 << m_who;
                e_rsp_id = m_own[m_who];
                m_op = OP_NONE;
            end else begin
                e_comp    = int'(m_ok);
                e_comp_id = m_ok ? m_own[m_who] : 0;
                if (m_ok) begin
                    m_busy[m_who] = 1'b0;
                    m_own[m_who]  = 0;
                end else begin
                    m_err = 1'b1;
                end
                m_op = OP_NONE;
            end
        end

        chk("clm_ready", int'(s_clm_rdy), e_clm);
        chk("cmp_ready", int'(s_cmp_rdy), e_cmp);
        chk("rsp_valid", int'(s_rsp_vld), e_rsp);
        chk("rsp_id", int'(s_rsp_id), e_rsp_id);
        chk("clam", int'(s_clam), e_clam);
        chk("comp", int'(s_comp), e_comp);
        chk("comp_id", int'(s_comp_id), e_comp_id);
        chk("busy", int'(s_busy), e_busy);
        chk("err", int'(s_err), e_err);

        // Requesters drop a request once the model says it was accepted.
        d_clm = d_clm & ~N'(e_clm);
        d_cmp = d_cmp & ~N'(e_cmp);
    endtask

    task automatic do_reset();
        d_rst = 1'b0; d_clm = '0; d_cmp = '0; d_clr = 1'b0;
        step();
        d_rst = 1'b1;
    endtask

    initial begin
        for (int j = 0; j < N; j++) m_own[j] = 0;

        // Reset state.
        do_reset();
        chk("rst_busy", int'(s_busy), 0);
        chk("rst_err", int'(s_err), 0);

        // Single claim from ctx1, core ID 7.
        d_id = 5'd7; d_clm = 4'b0010;
        step(); chk("t1_clm_ready", int'(s_clm_rdy), 4'b0010);
        step(); chk("t1_clam", int'(s_clam), 1);
        step(); chk("t1_rsp_valid", int'(s_rsp_vld), 4'b0010);
                chk("t1_rsp_id", int'(s_rsp_id), 7);
                chk("t1_busy", int'(s_busy), 4'b0010);

        // All four claim together from reset: grants 0,1,2,3 three cycles apart.
        do_reset();
        d_clm = 4'b1111;
        for (int g = 0; g < N; g++) begin
            step(); chk("t2_grant", int'(s_clm_rdy), 1 << g);
            d_id = W'(3 + g);
            step(); chk("t2_clam", int'(s_clam), 1);
            step(); chk("t2_rsp_valid", int'(s_rsp_vld), 1 << g);
                    chk("t2_rsp_id", int'(s_rsp_id), 3 + g);
        end

        // Complete beats a simultaneous claim.
        do_reset();
        d_id = 5'd9; d_clm = 4'b0100;
        step(); step(); step();
        d_cmp = 4'b0100; d_cmp_id[2] = 5'd9; d_clm = 4'b0001;
        step(); chk("t3_cmp_ready", int'(s_cmp_rdy), 4'b0100);
                chk("t3_no_claim", int'(s_clm_rdy), 0);
        step(); chk("t3_comp", int'(s_comp), 1);
                chk("t3_comp_id", int'(s_comp_id), 9);
        d_id = 5'd4;
        step(); chk("t3_busy", int'(s_busy), 0);
                chk("t3_ctx0_grant", int'(s_clm_rdy), 4'b0001);
        step(); step(); chk("t3_rsp_id", int'(s_rsp_id), 4);

        // Mismatched complete: ctx0 owns 4, completes 5.
        d_cmp = 4'b0001; d_cmp_id[0] = 5'd5;
        step(); chk("t4_cmp_ready", int'(s_cmp_rdy), 4'b0001);
        step(); chk("t4_comp", int'(s_comp), 0);
        step(); chk("t4_err", int'(s_err), 1);
                chk("t4_busy", int'(s_busy), 4'b0001);
        d_clr = 1'b1; step(); d_clr = 1'b0;
        step(); chk("t4_err_clr", int'(s_err), 0);

        // Zero ID claim by ctx3, then an unexpected complete from ctx3.
        d_id = 5'd0; d_clm = 4'b1000;
        step(); step();
        step(); chk("t5_rsp_valid", int'(s_rsp_vld), 4'b1000);
                chk("t5_rsp_id", int'(s_rsp_id), 0);
        step(); chk("t5_busy", int'(s_busy), 4'b0001);
        d_cmp = 4'b1000; d_cmp_id[3] = 5'd0;
        step(); step();
        step(); chk("t5_err", int'(s_err), 1);
        d_clr = 1'b1; step(); d_clr = 1'b0;

        // Reset during CLAIM: everything clears, next grant searches from ctx0.
        d_id = 5'd5; d_clm = 4'b0100;
        step(); chk("t6_grant", int'(s_clm_rdy), 4'b0100);
        d_rst = 1'b0;
        step(); chk("t6_clam", int'(s_clam), 0);
                chk("t6_busy", int'(s_busy), 0);
        d_rst = 1'b1; d_clm = 4'b1001;
        step(); chk("t6_first_grant", int'(s_clm_rdy), 4'b0001);
                chk("t6_no_rsp", int'(s_rsp_vld), 0);
        step(); step(); step();

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            for (int k = 0; k < N; k++) begin
                if (!d_clm[k] && $urandom_range(3) == 0) d_clm[k] = 1'b1;
                if (!d_cmp[k] && $urandom_range(7) == 0) begin
                    d_cmp[k] = 1'b1;
                    d_cmp_id[k] = ($urandom_range(5) == 0) ? W'($urandom) : W'(m_own[k]);
                end
            end
            d_id  = ($urandom_range(3) == 0) ? '0 : W'($urandom);
            d_clr = ($urandom_range(15) == 0);
            d_rst = ($urandom_range(499) != 0);
            step();
        end
        d_rst = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
